vga_scan_reader: RTL

VGA_SCAN_READER -- requirements
Module: vga_scan_reader

---
 rtl/vga_scan_reader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vga_scan_reader.sv
// vga_scan_reader: 640x480@60 VGA timing generator that scans a 160x120
// 3-bit framebuffer, pixel-doubling each framebuffer pixel 2^SCALE_SHIFT
// times per axis. The pixel clock is clk/2; everything runs in the clk
// domain, gated by the pixel tick.
//
// Read port: fb_addr is registered on a pixel tick; the memory must return
// fb_data one clk later. The colour stage samples fb_data on the following
// pixel tick (two clks after the address changed), so a one-clk synchronous
// RAM fits without any handshake.
//
// Optional build macro: SCANLINE_EFFECT_EN blanks the colour (not the
// syncs or blank_n) on odd screen lines.
module vga_scan_reader #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_W        = 160
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [14:0] fb_addr,
  input  logic [2:0]  fb_data,
  output logic [9:0]  vga_r,
  output logic [9:0]  vga_g,
  output logic [9:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        vga_clk,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic          phase;
  logic          pix_en;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;

  logic          raw_hs;
  logic          raw_vs;
  logic          raw_active;
  logic [14:0]   addr_next;

  logic          s1_hs;
  logic          s1_vs;
  logic          s1_active;
  logic          colour_on;

  // Pixel tick is every second clk; the phase bit doubles as the pixel clock.
  assign pix_en     = phase;
  assign vga_clk    = phase;
  assign vga_sync_n = 1'b0;

  // Raw timing decode for the counter position about to be sampled.
  assign raw_hs     = !((hcount >= H_SYNC_S) && (hcount < H_SYNC_E));
  assign raw_vs     = !((vcount >= V_SYNC_S) && (vcount < V_SYNC_E));
  assign raw_active = (hcount < H_ACT) && (vcount < V_ACT);
  assign addr_next  = 15'((int'(vcount) >> SCALE_SHIFT) * FB_W
                          + (int'(hcount) >> SCALE_SHIFT));

`ifdef SCANLINE_EFFECT_EN
  logic s1_odd;

  // Carry the line parity alongside the sync bits so the dimmed line stays
  // aligned with its own blank/sync.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_odd <= 1'b0;
    end else if (pix_en) begin
      s1_odd <= vcount[0];
    end
  end

  assign colour_on = s1_active && !s1_odd;
`else
  assign colour_on = s1_active;
`endif

  // Phase toggle: restarts at 0 so the first tick lands on the 2nd clk.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
    end
  end

  // Horizontal/vertical position counters, free running on pixel ticks.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + VW'(1);
      end else begin
        hcount <= hcount + HW'(1);
      end
    end
  end

  // Stage 1: issue the read and capture sync/active for this position.
  // Outside the visible area the address is left alone.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fb_addr   <= '0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_active <= 1'b0;
    end else if (pix_en) begin
      if (raw_active) begin
        fb_addr <= addr_next;
      end
      s1_hs     <= raw_hs;
      s1_vs     <= raw_vs;
      s1_active <= raw_active;
    end
  end

  // Stage 2: colour from the returned data, aligned with delayed sync/blank.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (pix_en) begin
      vga_r       <= colour_on ? {10{fb_data[2]}} : 10'd0;
      vga_g       <= colour_on ? {10{fb_data[1]}} : 10'd0;
      vga_b       <= colour_on ? {10{fb_data[0]}} : 10'd0;
      vga_hs      <= s1_hs;
      vga_vs      <= s1_vs;
      vga_blank_n <= s1_active;
    end
  end

  // One-clk pulse right after the tick that wraps the counters to (0,0).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && (hcount == H_LAST) && (vcount == V_LAST);
    end
  end

endmodule
